// File: rtl/prog_freq_div.sv
// Programmable multi-channel frequency divider: a free-running binary count plus
// NCH independently programmable tick / square-wave channels, all synchronous to clk.
module prog_freq_div #(
    parameter  int WIDTH   = 32,
    parameter  int NCH     = 4,
    parameter  int DEF_DIV = 2,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
    output logic [WIDTH-1:0] cnt,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q [NCH];
    logic [WIDTH-1:0] div_d [NCH];
    logic [WIDTH-1:0] c_q   [NCH];
    logic [WIDTH-1:0] c_d   [NCH];
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   sq_q, sq_d;
    logic             cfg_valid;

    // Writes addressed past the last channel are dropped.
    assign cfg_valid = cfg_we && (int'(cfg_ch) < NCH);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        cnt_d = en ? cnt_q + WIDTH'(1) : cnt_q;
        for (int i = 0; i < NCH; i++) begin
            div_d[i]  = div_q[i];
            c_d[i]    = c_q[i];
            tick_d[i] = 1'b0;
            sq_d[i]   = sq_q[i];
            if (sync) begin
                c_d[i]  = '0;
                sq_d[i] = 1'b0;
            end else if (cfg_valid && (int'(cfg_ch) == i)) begin
                div_d[i] = cfg_div;
                c_d[i]   = '0;
            end else if (div_q[i] == '0) begin
                c_d[i] = '0;
            end else if (en) begin
                // ">=" lets a ratio lowered below the running phase end on the next edge.
                if (c_q[i] >= div_q[i] - WIDTH'(1)) begin
                    c_d[i]    = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                end else begin
                    c_d[i] = c_q[i] + WIDTH'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= '0;
            sq_q   <= '0;
            // NOTE: the ratio array is reset because the channels must come up dividing by DEF_DIV.
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= WIDTH'(DEF_DIV);
                c_q[i]   <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= div_d[i];
                c_q[i]   <= c_d[i];
            end
        end
    end

    assign cnt  = cnt_q;
    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

// File: doc/prog_freq_div.md
PROG_FREQ_DIV -- requirements
Module: prog_freq_div

Interface
REQ-001 Parameter WIDTH, default 32: width of the free-running count and of every divide ratio.
REQ-002 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-003 Parameter DEF_DIV, default 2: divide ratio loaded into every channel at reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  global count enable; low = all counters, ticks and square outputs frozen.
REQ-007 sync  input  1  phase-align pulse: restart all channel counters together.
REQ-008 cfg_we  input  1  configuration write strobe, single cycle.
REQ-009 cfg_ch  input  max(1,$clog2(NCH))  channel index for the write.
REQ-010 cfg_div  input  WIDTH  new divide ratio for the selected channel.
REQ-011 cnt  output  WIDTH  free-running synchronous up-count (binary, same bit weights as a ripple divider chain).
REQ-012 tick  output  NCH  per-channel one-cycle pulse, registered.
REQ-013 sq  output  NCH  per-channel square wave, registered, period 2*div enabled cycles.

Function
REQ-014 cnt SHALL increment by 1 on each edge with en=1 and wrap from 2^WIDTH-1 to 0; hold when en=0; unaffected by sync and cfg_we.
REQ-015 Each channel i SHALL hold a divide register div[i] (WIDTH bits) and a phase counter c[i] (WIDTH bits).
REQ-016 Enabled edge, div[i]>=1, c[i]>=div[i]-1 (terminal): c[i]<=0, tick[i]<=1, sq[i]<=~sq[i].
REQ-017 Enabled edge, non-terminal: c[i]<=c[i]+1, tick[i]<=0, sq[i] holds.
REQ-018 en=0: tick[i]<=0; c[i], sq[i], cnt hold.
REQ-019 div[i]=0: channel disabled; c[i]<=0, tick[i]<=0, sq[i] holds regardless of en.
REQ-020 div[i]=1: tick[i] high on every enabled cycle; sq[i] toggles every enabled cycle.
REQ-021 The ">=" terminal compare SHALL ensure a ratio lowered below the current c[i] terminates on the next enabled edge, with no 2^WIDTH wrap.
REQ-022 cfg_we=1 with cfg_ch<NCH: div[cfg_ch]<=cfg_div, c[cfg_ch]<=0, tick[cfg_ch]<=0, sq[cfg_ch] holds; applies even when en=0.
REQ-023 cfg_we=1 with cfg_ch>=NCH: ignored, no state change.
REQ-024 sync=1: every c[i]<=0, tick[i]<=0, sq[i]<=0; div[] unchanged; applies even when en=0.
REQ-025 Priority, highest first: rst, sync, cfg_we, terminal/increment; a write coinciding with a channel's terminal cycle suppresses that tick.
REQ-026 Non-addressed channels SHALL be unaffected by a cfg write.
REQ-027 No derived clocks; all outputs are synchronous to clk (replaces inverted-Q ripple clocking).

Reset
REQ-028 While rst=1 at an edge: cnt<=0, c[i]<=0, tick<=0, sq<=0, div[i]<=DEF_DIV; rst overrides en, sync and cfg_we.
REQ-029 Reset mid-count SHALL discard phase; the first tick after release occurs on the div[i]-th enabled edge.

Verification
REQ-030 Reset release, en=1, defaults (WIDTH=32, NCH=4, DEF_DIV=2) -> cnt=1,2,3...; tick[i] high after edges 2,4,6...; sq[i] toggles at each tick.
REQ-031 Write ch1 div=5, en=1 -> tick[1] after every 5th edge, sq[1] period 10 cycles; ch0/2/3 keep period 2.
REQ-032 ch2 div=10 with c[2]=7, write div=3 -> c[2] restarts at 0, first tick on 3rd edge; repeat without write via div change test: c=7>=div-1 -> tick next edge.
REQ-033 div=0 on ch3 -> tick[3]=0 indefinitely, sq[3] frozen; div=1 on ch0 -> tick[0] constant 1 while en=1.
REQ-034 en toggled 0 for 4 cycles mid-period -> ticks delayed exactly 4 cycles, cnt frozen; WIDTH=4 run -> cnt wraps 15->0.
REQ-035 sync asserted with cfg_we on same edge, and cfg_ch=NCH -> all sq=0, c=0, div unchanged; out-of-range write has no effect.
